// File: rtl/man_frame_encoder.sv
// Manchester frame encoder: accepts a DATA_W word per valid/ready handshake,
// prepends PRE_W zero bits and serialises the frame MSB-first as Manchester
// half-bits of (_divide+1) clocks each, followed by an IDLE_GAP-clock idle gap.
module man_frame_encoder #(
  parameter int DATA_W   = 8,
  parameter int PRE_W    = 2,
  parameter int DIV_W    = 32,
  parameter int IDLE_GAP = 10
) (
  input  logic              _clk,
  input  logic              _rst,
  input  logic [DATA_W-1:0] _data,
  input  logic              _valid,
  output logic              _ready,
  input  logic [DIV_W-1:0]  _divide,
  input  logic              _polarity,
  input  logic              _idle_level,
  output logic              _output_wire,
  output logic              _busy,
  output logic              _done
);

  localparam int N   = PRE_W + DATA_W;
  localparam int K_W = $clog2(2 * N + 1);
  localparam int G_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(2 * N - 1);
  localparam logic [G_W-1:0] G_LOAD = (IDLE_GAP > 0) ? G_W'(IDLE_GAP - 1) : {G_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    GAP      = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [N-1:0]       sreg_r, sreg_s;
  logic [N-1:0]       load_s, shifted_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [DIV_W-1:0]   half_cnt_r, half_cnt_s;
  logic               pol_r, pol_s;
  logic [K_W-1:0]     k_r, k_s;
  logic [G_W-1:0]     gap_cnt_r, gap_cnt_s;
  logic               line_r, line_s;
  logic               done_r, done_s;
  logic               ready_r, ready_s;
  logic               busy_r, busy_s;

  assign _ready       = ready_r;
  assign _busy        = busy_r;
  assign _done        = done_r;
  assign _output_wire = line_r;

  // Next-state, counter and line-level decode; the current bit always sits at sreg MSB.
  always_comb begin
    state_s    = state_r;
    sreg_s     = sreg_r;
    div_s      = div_r;
    half_cnt_s = half_cnt_r;
    pol_s      = pol_r;
    k_s        = k_r;
    gap_cnt_s  = gap_cnt_r;
    line_s     = line_r;
    done_s     = 1'b0;
    load_s     = {N{1'b0}};
    load_s[DATA_W-1:0] = _data;
    shifted_s  = sreg_r << 1;

    case (state_r)
      IDLE: begin
        line_s = _idle_level;
        if (_valid && ready_r) begin
          sreg_s     = load_s;
          div_s      = _divide;
          pol_s      = _polarity;
          half_cnt_s = _divide;
          k_s        = {K_W{1'b0}};
          line_s     = load_s[N-1] ^ _polarity;
          state_s    = TRANSFER;
        end else begin
          state_s = IDLE;
        end
      end
      TRANSFER: begin
        if (half_cnt_r == {DIV_W{1'b0}}) begin
          half_cnt_s = div_r;
          if (k_r == K_LAST) begin
            line_s = _idle_level;
            done_s = 1'b1;
            k_s    = {K_W{1'b0}};
            if (IDLE_GAP == 0) begin
              state_s = IDLE;
            end else begin
              state_s   = GAP;
              gap_cnt_s = G_LOAD;
            end
          end else begin
            k_s = k_r + 1'b1;
            if (!k_r[0]) begin
              // second half of the same bit is the complement of the first
              line_s = ~line_r;
            end else begin
              sreg_s = shifted_s;
              line_s = shifted_s[N-1] ^ pol_r;
            end
          end
        end else begin
          half_cnt_s = half_cnt_r - 1'b1;
        end
      end
      GAP: begin
        line_s = _idle_level;
        if (gap_cnt_r == {G_W{1'b0}}) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        line_s  = _idle_level;
      end
    endcase

    ready_s = (state_s == IDLE);
    busy_s  = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge _clk) begin
    if (_rst) begin
      state_r    <= IDLE;
      sreg_r     <= {N{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      half_cnt_r <= {DIV_W{1'b0}};
      pol_r      <= 1'b0;
      k_r        <= {K_W{1'b0}};
      gap_cnt_r  <= {G_W{1'b0}};
      line_r     <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sreg_r     <= sreg_s;
      div_r      <= div_s;
      half_cnt_r <= half_cnt_s;
      pol_r      <= pol_s;
      k_r        <= k_s;
      gap_cnt_r  <= gap_cnt_s;
      line_r     <= line_s;
      done_r     <= done_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
    end
  end

endmodule

// File: tb/tb_man_frame_encoder.sv
// Self-checking bench for man_frame_encoder: a scoreboard queue of expected
// line levels is filled at each accept and drained cycle by cycle.
module tb_man_frame_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        valid, valid1;
  logic        ready, ready1;
  logic [31:0] divide;
  logic        polarity;
  logic        idle_level;
  logic        line, line1;
  logic        busy, busy1;
  logic        done, done1;

  int n_checks = 0;
  int n_fail   = 0;
  bit q[$];
  logic [19:0] wave;
  logic [19:0] exp_wave = 20'b01011001100101100110;
  logic [19:0] inv_wave;

  always #5 clk = ~clk;

  man_frame_encoder #(.DATA_W(8), .PRE_W(2), .DIV_W(32), .IDLE_GAP(10)) u_dut (
    ._clk(clk), ._rst(rst), ._data(data), ._valid(valid), ._ready(ready),
    ._divide(divide), ._polarity(polarity), ._idle_level(idle_level),
    ._output_wire(line), ._busy(busy), ._done(done)
  );

  man_frame_encoder #(.DATA_W(8), .PRE_W(2), .DIV_W(32), .IDLE_GAP(0)) u_dut_nogap (
    ._clk(clk), ._rst(rst), ._data(data), ._valid(valid1), ._ready(ready1),
    ._divide(divide), ._polarity(polarity), ._idle_level(idle_level),
    ._output_wire(line1), ._busy(busy1), ._done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for every clock of the frame.
  task automatic push_frame(input logic [7:0] d, input int div, input logic pol);
    logic [9:0] f;
    logic b;
    f = {2'b00, d};
    for (int i = 9; i >= 0; i--) begin
      b = f[i] ^ pol;
      for (int h = 0; h < 2; h++) begin
        for (int c = 0; c <= div; c++) begin
          q.push_back((h == 0) ? b : ~b);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where ready is back high.
  task automatic run_frame(input logic [7:0] d, input int div, input logic pol,
                           input bit hold, input bit toggle, input int exp_wait);
    int w;
    int len;
    bit v;
    data = d; divide = div; polarity = pol; valid = 1'b1;
    w = 0;
    while (!ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_wait >= 0) check("accept_wait", w, exp_wait);
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      valid = 1'b0;
      return;
    end
    push_frame(d, div, pol);
    len = q.size();
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
    if (toggle) begin
      divide = div + 5; polarity = ~pol; data = ~d;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      v = q.pop_front();
      if (i < 20) wave[19-i] = line;
      check("line", line, v);
      check("done_in_frame", done, 0);
      if (i == 0) begin
        check("busy_frame", busy, 1);
        check("ready_frame", ready, 0);
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("line_after_frame", line, idle_level);
    check("busy_gap", busy, 1);
    check("ready_gap", ready, 0);
    w = 0;
    while (!ready && w < 300) begin
      @(negedge clk);
      w++;
      if (w == 1) check("done_one_cycle", done, 0);
    end
    check("gap_len", w, 10);
  endtask

  initial begin
    inv_wave = ~exp_wave;
    rst = 1'b1; valid = 1'b0; valid1 = 1'b0; data = 8'h00;
    divide = 32'd0; polarity = 1'b0; idle_level = 1'b1;

    // 1: reset values, then idle line follows idle_level
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_line", line, 0);
    check("rst_line_nogap", line1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", ready, 1);
    check("rel_line", line, 1);
    check("rel_busy", busy, 0);

    // 2: 8'hA5, divide 0, polarity 0
    run_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0, 0);
    check("wave_a5", wave, exp_wave);

    // 3: same, inverted polarity
    run_frame(8'hA5, 0, 1'b1, 1'b0, 1'b0, 0);
    check("wave_a5_inv", wave, inv_wave);

    // 4: divide 3 with mid-frame input changes, idle level low
    idle_level = 1'b0;
    run_frame(8'h3C, 3, 1'b0, 1'b0, 1'b1, 0);
    idle_level = 1'b1;
    @(negedge clk);
    check("idle_line_high", line, 1);

    // 5: back-to-back with valid held high
    run_frame(8'h00, 0, 1'b0, 1'b1, 1'b0, 0);
    run_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0, 0);

    // 6: reset at half-bit 7, then a clean frame
    data = 8'hC3; divide = 32'd0; polarity = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_line", line, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", ready, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", ready, 1);
    check("postrst_done", done, 0);
    check("postrst_line", line, 1);
    run_frame(8'h81, 0, 1'b0, 1'b0, 1'b0, 0);

    // IDLE_GAP = 0 build: done and ready together
    data = 8'h5A; divide = 32'd0; polarity = 1'b0; valid1 = 1'b1;
    check("nogap_ready", ready1, 1);
    push_frame(8'h5A, 0, 1'b0);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("nogap_line", line1, q.pop_front());
    end
    @(negedge clk);
    check("nogap_done", done1, 1);
    check("nogap_ready_with_done", ready1, 1);
    check("nogap_busy", busy1, 0);
    check("nogap_line_idle", line1, idle_level);
    @(negedge clk);
    check("nogap_done_clear", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
